controlador_semaforo: RTL and testbench

CONTROLADOR_SEMAFORO -- requirements
Module: controlador_semaforo

---
 rtl/controlador_semaforo_pkg.sv | 24 ++
 rtl/controlador_semaforo_if.sv | 35 +++
 rtl/controlador_semaforo_contador_descendente.sv | 45 ++++
 rtl/controlador_semaforo.sv | 174 +++++++++++++++++
 tb/tb_controlador_semaforo.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/controlador_semaforo_pkg.sv
// ---------------------------------------------------------------------------
// pacote_semaforo
// Shared constants for the traffic-light controller:
//   - estado_t : FSM state codes, which are also the external 'fase' codes
//   - TIMER_W  : width of the phase down-counter
//   - carga_fase() : counter reload value for a phase lasting t cycles
// ---------------------------------------------------------------------------
package pacote_semaforo;

    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        VERDE    = 2'b01,
        AMARELO  = 2'b10,
        VERMELHO = 2'b11
    } estado_t;

    // A phase of t cycles starts the counter at t-1 and leaves when it hits 0.
    function automatic logic [TIMER_W-1:0] carga_fase(input int t);
        return TIMER_W'(t - 1);
    endfunction

endpackage

// File: rtl/controlador_semaforo_if.sv
// ---------------------------------------------------------------------------
// controlador_semaforo_if
// Control inputs and lamp/status outputs of the traffic-light controller.
//   start, stop, req_ped            : level requests sampled every cycle
//   fase                            : current phase code (estado_t encoding)
//   luz_verde/amarelo/vermelho      : one-hot lamp drives
//   ped_ok                          : pedestrian crossing permitted
//   fim_ciclo                       : one-cycle pulse after a red phase ends
//   busy                            : controller is not idle
// Modports: slave = controller side, master = driver/observer side.
// ---------------------------------------------------------------------------
interface controlador_semaforo_if;

    logic       start;
    logic       stop;
    logic       req_ped;
    logic [1:0] fase;
    logic       luz_verde;
    logic       luz_amarelo;
    logic       luz_vermelho;
    logic       ped_ok;
    logic       fim_ciclo;
    logic       busy;

    modport slave (
        input  start, stop, req_ped,
        output fase, luz_verde, luz_amarelo, luz_vermelho, ped_ok, fim_ciclo, busy
    );

    modport master (
        output start, stop, req_ped,
        input  fase, luz_verde, luz_amarelo, luz_vermelho, ped_ok, fim_ciclo, busy
    );

endinterface

// File: rtl/controlador_semaforo_contador_descendente.sv
// ---------------------------------------------------------------------------
// contador_descendente
// Loadable down-counter used to time each phase.
//   clk, rstn   : clock, asynchronous active-low reset (count -> 0)
//   load_i      : load valor_i (has priority over en_i)
//   valor_i     : value to load
//   en_i        : decrement by one; saturates at zero
//   contagem_o  : current count
//   zero_o      : count equals zero
// ---------------------------------------------------------------------------
module contador_descendente
    import pacote_semaforo::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] valor_i,
    input  logic               en_i,
    output logic [TIMER_W-1:0] contagem_o,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (load_i) begin
            cont_d = valor_i;
        end else if (en_i && (cont_q != '0)) begin
            cont_d = cont_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign contagem_o = cont_q;
    assign zero_o     = (cont_q == '0);

endmodule

// File: rtl/controlador_semaforo.sv
// ---------------------------------------------------------------------------
// controlador_semaforo
// Traffic-light controller: IDLE -> VERDE -> AMARELO -> VERMELHO -> VERDE ...
// Each phase lasts T_x cycles, timed by a down-counter. A pedestrian request
// during green shortens it and grants ped_ok for the following red phase.
// A stop request is remembered and honoured only at the end of red.
// Parameters: T_VERDE, T_AMARELO, T_VERMELHO (phase lengths, 1..15 cycles)
// Ports:
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : controlador_semaforo_if.slave (requests in, lamps/status out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module controlador_semaforo
    import pacote_semaforo::*;
#(
    parameter int T_VERDE    = 5,
    parameter int T_AMARELO  = 2,
    parameter int T_VERMELHO = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    controlador_semaforo_if.slave   bus
);

    estado_t estado_q, estado_d;
    logic    stop_pend_q, stop_pend_d;
    logic    ped_pend_q, ped_pend_d;

    logic [1:0] fase_q, fase_d;
    logic       luz_verde_q, luz_verde_d;
    logic       luz_amarelo_q, luz_amarelo_d;
    logic       luz_vermelho_q, luz_vermelho_d;
    logic       ped_ok_q, ped_ok_d;
    logic       fim_ciclo_q, fim_ciclo_d;
    logic       busy_q, busy_d;

    logic               cnt_load;
    logic [TIMER_W-1:0] cnt_valor;
    logic               cnt_en;
    logic [TIMER_W-1:0] cnt_contagem;
    logic               cnt_zero;

    contador_descendente u_contador (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (cnt_load),
        .valor_i    (cnt_valor),
        .en_i       (cnt_en),
        .contagem_o (cnt_contagem),
        .zero_o     (cnt_zero)
    );

    // Next state, pending flags and counter control
    always_comb begin
        estado_d    = estado_q;
        stop_pend_d = stop_pend_q;
        ped_pend_d  = ped_pend_q;
        cnt_load    = 1'b0;
        cnt_valor   = '0;
        cnt_en      = 1'b0;
        fim_ciclo_d = 1'b0;

        unique case (estado_q)
            IDLE: begin
                // stop has priority over start while idle
                if (bus.start && !bus.stop) begin
                    estado_d  = VERDE;
                    cnt_load  = 1'b1;
                    cnt_valor = carga_fase(T_VERDE);
                end
            end

            VERDE: begin
                if (bus.stop)    stop_pend_d = 1'b1;
                if (bus.req_ped) ped_pend_d  = 1'b1;
                if (cnt_zero) begin
                    estado_d  = AMARELO;
                    cnt_load  = 1'b1;
                    cnt_valor = carga_fase(T_AMARELO);
                end else if (bus.req_ped && (cnt_contagem > TIMER_W'(1))) begin
                    // Shorten green: exactly two more green cycles after the request edge
                    cnt_load  = 1'b1;
                    cnt_valor = TIMER_W'(1);
                end else begin
                    cnt_en = 1'b1;
                end
            end

            AMARELO: begin
                if (bus.stop)    stop_pend_d = 1'b1;
                if (bus.req_ped) ped_pend_d  = 1'b1;
                if (cnt_zero) begin
                    estado_d  = VERMELHO;
                    cnt_load  = 1'b1;
                    cnt_valor = carga_fase(T_VERMELHO);
                end else begin
                    cnt_en = 1'b1;
                end
            end

            VERMELHO: begin
                if (bus.stop) stop_pend_d = 1'b1;
                if (cnt_zero) begin
                    fim_ciclo_d = 1'b1;
                    ped_pend_d  = 1'b0;
                    // A stop seen on this very edge still ends the run here
                    if (stop_pend_q || bus.stop) begin
                        estado_d    = IDLE;
                        stop_pend_d = 1'b0;
                        cnt_load    = 1'b1;
                        cnt_valor   = '0;
                    end else begin
                        estado_d  = VERDE;
                        cnt_load  = 1'b1;
                        cnt_valor = carga_fase(T_VERDE);
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that they can be registered
    always_comb begin
        fase_d         = estado_d;
        luz_verde_d    = (estado_d == VERDE);
        luz_amarelo_d  = (estado_d == AMARELO);
        luz_vermelho_d = (estado_d == IDLE) || (estado_d == VERMELHO);
        busy_d         = (estado_d != IDLE);
        // ped_pend cannot change during red, so its value at entry holds throughout
        ped_ok_d       = (estado_d == VERMELHO) && ped_pend_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            estado_q       <= IDLE;
            stop_pend_q    <= 1'b0;
            ped_pend_q     <= 1'b0;
            fase_q         <= IDLE;
            luz_verde_q    <= 1'b0;
            luz_amarelo_q  <= 1'b0;
            luz_vermelho_q <= 1'b1;
            ped_ok_q       <= 1'b0;
            fim_ciclo_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            stop_pend_q    <= stop_pend_d;
            ped_pend_q     <= ped_pend_d;
            fase_q         <= fase_d;
            luz_verde_q    <= luz_verde_d;
            luz_amarelo_q  <= luz_amarelo_d;
            luz_vermelho_q <= luz_vermelho_d;
            ped_ok_q       <= ped_ok_d;
            fim_ciclo_q    <= fim_ciclo_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.fase         = fase_q;
    assign bus.luz_verde    = luz_verde_q;
    assign bus.luz_amarelo  = luz_amarelo_q;
    assign bus.luz_vermelho = luz_vermelho_q;
    assign bus.ped_ok       = ped_ok_q;
    assign bus.fim_ciclo    = fim_ciclo_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_controlador_semaforo.sv
// ---------------------------------------------------------------------------
// tb_controlador_semaforo
// Bench for controlador_semaforo: a default-timed instance driven from a
// table of per-cycle vectors, plus a 1/1/1-timed instance and hand-written
// sequences for asynchronous reset and the shortest phases.
// ---------------------------------------------------------------------------
module tb_controlador_semaforo;

    logic clk;
    logic rstn;

    controlador_semaforo_if bus0();
    controlador_semaforo_if bus1();

    controlador_semaforo u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus0)
    );

    controlador_semaforo #(
        .T_VERDE    (1),
        .T_AMARELO  (1),
        .T_VERMELHO (1)
    ) u_dut_rapido (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // One row: inputs held during cycle k, outputs expected in cycle k+1
    typedef struct {
        logic       start;
        logic       stop;
        logic       req;
        logic [1:0] fase;
        logic       ped;
        logic       fim;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic st, input logic r,
                                input logic [1:0] f, input logic p, input logic fm);
        vec_t v;
        v.start = s; v.stop = st; v.req = r; v.fase = f; v.ped = p; v.fim = fm;
        return v;
    endfunction

    // Expected output word {fase, verde, amarelo, vermelho, ped_ok, fim_ciclo, busy}
    function automatic logic [7:0] esperado(input logic [1:0] f, input logic p, input logic fm);
        return {f, (f == 2'b01), (f == 2'b10), (f == 2'b00 || f == 2'b11), p, fm, (f != 2'b00)};
    endfunction

    function automatic logic [7:0] saida0();
        return {bus0.fase, bus0.luz_verde, bus0.luz_amarelo, bus0.luz_vermelho,
                bus0.ped_ok, bus0.fim_ciclo, bus0.busy};
    endfunction

    function automatic logic [7:0] saida1();
        return {bus1.fase, bus1.luz_verde, bus1.luz_amarelo, bus1.luz_vermelho,
                bus1.ped_ok, bus1.fim_ciclo, bus1.busy};
    endfunction

    task automatic chk(input string nome, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {fase,G,Y,R,ped,fim,busy}=%b required %b", nome, got, exp);
        end
    endtask

    task automatic passo0(input logic s, input logic st, input logic r);
        bus0.start   = s;
        bus0.stop    = st;
        bus0.req_ped = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstn         = 1'b0;
        bus0.start   = 1'b0;
        bus0.stop    = 1'b0;
        bus0.req_ped = 1'b0;
        bus1.start   = 1'b0;
        bus1.stop    = 1'b0;
        bus1.req_ped = 1'b0;

        // Normal cycle, then a cycle shortened by a pedestrian, then a stop
        tbl.push_back(mk(1, 0, 0, 2'b01, 0, 0));                      // c1 VERDE
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 2'b01, 0, 0)); // c2-5
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 2'b10, 0, 0)); // c6-7
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 2'b11, 0, 0)); // c8-11
        tbl.push_back(mk(0, 0, 0, 2'b01, 0, 1));                      // c12 fim
        tbl.push_back(mk(0, 0, 0, 2'b01, 0, 0));                      // c13
        tbl.push_back(mk(0, 0, 1, 2'b01, 0, 0));                      // req at c13 -> c14
        tbl.push_back(mk(0, 0, 0, 2'b01, 0, 0));                      // c15
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 2'b10, 0, 0)); // c16-17
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 2'b11, 1, 0)); // c18-21 ped_ok
        tbl.push_back(mk(0, 0, 0, 2'b01, 0, 1));                      // c22 fim, ped_ok off
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 2'b01, 0, 0)); // c23-26
        tbl.push_back(mk(0, 0, 0, 2'b10, 0, 0));                      // c27 AMARELO
        tbl.push_back(mk(0, 1, 0, 2'b10, 0, 0));                      // stop at c27 -> c28
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 2'b11, 0, 0)); // c29-32
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 1));                      // c33 IDLE, fim
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0));                      // c34
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 1, 0, 2'b00, 0, 0)); // start+stop

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_dut", saida0(), esperado(2'b00, 0, 0));
        chk("reset_rapido", saida1(), esperado(2'b00, 0, 0));
        rstn = 1'b1;

        // Table-driven run
        for (int i = 0; i < tbl.size(); i++) begin
            passo0(tbl[i].start, tbl[i].stop, tbl[i].req);
            chk($sformatf("tab[%0d]", i), saida0(), esperado(tbl[i].fase, tbl[i].ped, tbl[i].fim));
        end

        // Asynchronous reset between clock edges in the middle of green
        passo0(1, 0, 0);
        chk("rst_pre_verde1", saida0(), esperado(2'b01, 0, 0));
        passo0(0, 0, 0);
        chk("rst_pre_verde2", saida0(), esperado(2'b01, 0, 0));
        #2 rstn = 1'b0;
        #1 chk("rst_async", saida0(), esperado(2'b00, 0, 0));
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_pos_idle", saida0(), esperado(2'b00, 0, 0));
        for (int i = 0; i < 4; i++) begin
            passo0(0, 0, 0);
            chk($sformatf("rst_parado[%0d]", i), saida0(), esperado(2'b00, 0, 0));
        end
        passo0(1, 0, 0);
        chk("rst_novo_start", saida0(), esperado(2'b01, 0, 0));
        bus0.start = 1'b0;

        // One-cycle phases: 01,10,11 repeating, fim_ciclo on each return to green
        bus1.start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            logic [1:0] f;
            logic       fm;
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            f  = 2'((k - 1) % 3 + 1);
            fm = (k >= 4) && (f == 2'b01);
            chk($sformatf("rapido[%0d]", k), saida1(), esperado(f, 0, fm));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
